// File: rtl/axi4s_packet_tx.sv
// ---------------------------------------------------------------------------
// axi4s_packet_tx
// AXI4-Stream master that sends words from an internal FIFO as fixed-length
// packets of PKT_LEN beats. TLAST marks the final beat of each packet, and the
// block fully honours TREADY backpressure. A packet starts only once all of its
// beats are in the FIFO, so TVALID never drops in the middle of a packet.
// A packet counter and a running sum of the sent data support end-to-end
// checking against the receiver.
//
// Ports
//   clk            in   1       single clock, all state changes on posedge
//   rst            in   1       synchronous reset, active-high
//   wr_en          in   1       push wr_data into the FIFO this cycle
//   wr_data        in   DATA_W  word to push
//   wr_full        out  1       FIFO holds FIFO_DEPTH words
//   m_axis_tdata   out  DATA_W  stream data (FIFO head)
//   m_axis_tvalid  out  1       stream valid (FSM in SEND)
//   m_axis_tready  in   1       stream ready from the receiver
//   m_axis_tlast   out  1       high on beat PKT_LEN-1 of each packet
//   pkt_count      out  16      packets completed, wraps
//   tx_sum         out  32      modulo-2^32 sum of accepted TDATA
//   busy           out  1       FSM in SEND
// ---------------------------------------------------------------------------
module axi4s_packet_tx #(
  parameter int DATA_W     = 32,
  parameter int PKT_LEN    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [15:0]       pkt_count,
  output logic [31:0]       tx_sum,
  output logic              busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);
  localparam logic [OCC_W-1:0]  OCC_PKT   = OCC_W'(PKT_LEN);
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);
  // A one-beat packet carries TLAST on its very first beat.
  localparam logic              FIRST_IS_LAST = (PKT_LEN == 1) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Advance a FIFO pointer with explicit wrap so any depth indexes safely.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic              wr_full_r;

  state_t            state_r;
  logic [BEAT_W-1:0] beat_r;
  logic              tlast_r;
  logic [15:0]       pkt_count_r;
  logic [31:0]       tx_sum_r;

  logic              wr_acc_s;
  logic              pop_s;
  logic [OCC_W-1:0]  occ_next_s;
  logic [BEAT_W-1:0] beat_inc_s;

  // FIFO handshake decode and next occupancy (includes this cycle's write).
  always_comb begin
    wr_acc_s   = wr_en && !wr_full_r;
    pop_s      = (state_r == SEND) && m_axis_tready;
    beat_inc_s = beat_r + BEAT_W'(1);
    occ_next_s = occ_r;
    if (wr_acc_s && !pop_s) begin
      occ_next_s = occ_r + OCC_W'(1);
    end else if (!wr_acc_s && pop_s) begin
      occ_next_s = occ_r - OCC_W'(1);
    end else begin
      occ_next_s = occ_r;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      wr_full_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      occ_r     <= occ_next_s;
      wr_full_r <= (occ_next_s == OCC_FULL);
    end
  end

  // Packet FSM with beat counter, TLAST, packet counter and data sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_r      <= {BEAT_W{1'b0}};
      tlast_r     <= 1'b0;
      pkt_count_r <= 16'd0;
      tx_sum_r    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // Registered occupancy: a write landing on this edge is not counted.
          if (occ_r >= OCC_PKT) begin
            state_r <= SEND;
            beat_r  <= {BEAT_W{1'b0}};
            tlast_r <= FIRST_IS_LAST;
          end
        end
        SEND: begin
          if (pop_s) begin
            tx_sum_r <= tx_sum_r + 32'(m_axis_tdata);
            if (tlast_r) begin
              beat_r      <= {BEAT_W{1'b0}};
              pkt_count_r <= pkt_count_r + 16'd1;
              // Continue straight into the next packet when it is complete.
              if (occ_next_s >= OCC_PKT) begin
                state_r <= SEND;
                tlast_r <= FIRST_IS_LAST;
              end else begin
                state_r <= IDLE;
                tlast_r <= 1'b0;
              end
            end else begin
              beat_r  <= beat_inc_s;
              tlast_r <= (beat_inc_s == LAST_BEAT);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= {BEAT_W{1'b0}};
          tlast_r <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = mem_r[rd_ptr_r];
  assign m_axis_tvalid = (state_r == SEND);
  assign m_axis_tlast  = tlast_r;
  assign busy          = (state_r == SEND);
  assign wr_full       = wr_full_r;
  assign pkt_count     = pkt_count_r;
  assign tx_sum        = tx_sum_r;

endmodule

// File: tb/tb_axi4s_packet_tx.sv
// ---------------------------------------------------------------------------
// tb_axi4s_packet_tx
// Directed bench for axi4s_packet_tx (DATA_W=32, PKT_LEN=4, FIFO_DEPTH=8).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, so every sample shows the state left by the previous edge.
// ---------------------------------------------------------------------------
module tb_axi4s_packet_tx;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] pkt_count;
  logic [31:0] tx_sum;
  logic        busy;

  int errors = 0;
  int checks = 0;

  axi4s_packet_tx #(
    .DATA_W(32),
    .PKT_LEN(4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_full(wr_full),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count),
    .tx_sum(tx_sum),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL rst_wr_full got %b want 0", wr_full); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt_count got %0d want 0", pkt_count); end
    checks++; if (tx_sum !== 32'd0) begin errors++; $display("FAIL rst_tx_sum got %0d want 0", tx_sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  // Scenario 1: one packet 1,2,3,4 with tready held high.
  task automatic test_basic_packet();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_valid_early got %b want 0", m_axis_tvalid); end
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t1_valid beat %0d got %b want 1", b, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'(b + 1)) begin errors++; $display("FAIL t1_data beat %0d got %0d want %0d", b, m_axis_tdata, b + 1); end
      checks++; if (m_axis_tlast !== (b == 3)) begin errors++; $display("FAIL t1_last beat %0d got %b want %b", b, m_axis_tlast, (b == 3)); end
      tick();
    end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t1_valid_end got %b want 0", m_axis_tvalid); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL t1_pkt_count got %0d want 1", pkt_count); end
    checks++; if (tx_sum !== 32'd10) begin errors++; $display("FAIL t1_tx_sum got %0d want 10", tx_sum); end
  endtask

  // Scenario 2: incomplete packet is held back until its last word arrives.
  task automatic test_partial_hold();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 32'(10 * i);
      tick();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t2_hold cycle %0d got %b want 0", c, m_axis_tvalid); end
      tick();
    end
    wr_en = 1'b1; wr_data = 32'd40;
    tick();
    wr_en = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t2_valid_early got %b want 0", m_axis_tvalid); end
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t2_valid beat %0d got %b want 1", b, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'(10 * (b + 1))) begin errors++; $display("FAIL t2_data beat %0d got %0d want %0d", b, m_axis_tdata, 10 * (b + 1)); end
      tick();
    end
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL t2_pkt_count got %0d want 2", pkt_count); end
    checks++; if (tx_sum !== 32'd110) begin errors++; $display("FAIL t2_tx_sum got %0d want 110", tx_sum); end
  endtask

  // Scenario 3: tready toggles; data and tlast must hold through stalls.
  task automatic test_backpressure();
    int   idx;
    logic tr;
    m_axis_tready = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    idx = 0;
    tr  = 1'b0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      m_axis_tready = tr;
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t3_valid cycle %0d got %b want 1", c, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'(5 + idx)) begin errors++; $display("FAIL t3_data cycle %0d got %0d want %0d", c, m_axis_tdata, 5 + idx); end
      checks++; if (m_axis_tlast !== (idx == 3)) begin errors++; $display("FAIL t3_last cycle %0d got %b want %b", c, m_axis_tlast, (idx == 3)); end
      tick();
      if (tr) idx++;
      tr = ~tr;
    end
    m_axis_tready = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL t3_timeout beats got %0d want 4", idx); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t3_valid_end got %b want 0", m_axis_tvalid); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL t3_pkt_count got %0d want 3", pkt_count); end
    checks++; if (tx_sum !== 32'd136) begin errors++; $display("FAIL t3_tx_sum got %0d want 136", tx_sum); end
  endtask

  // Scenario 4: fill to full, drop a ninth write, drain two back-to-back packets.
  task automatic test_full_back_to_back();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
      if (i == 7) begin
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL t4_full_at7 got %b want 0", wr_full); end
      end
    end
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL t4_full got %b want 1", wr_full); end
    wr_data = 32'd99;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL t4_full_after_drop got %b want 1", wr_full); end
    m_axis_tready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t4_valid beat %0d got %b want 1", b, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'(b + 1)) begin errors++; $display("FAIL t4_data beat %0d got %0d want %0d", b, m_axis_tdata, b + 1); end
      checks++; if (m_axis_tlast !== (b == 3 || b == 7)) begin errors++; $display("FAIL t4_last beat %0d got %b want %b", b, m_axis_tlast, (b == 3 || b == 7)); end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t4_no_99 cycle %0d got valid %b data %0d want valid 0", c, m_axis_tvalid, m_axis_tdata); end
      tick();
    end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL t4_full_end got %b want 0", wr_full); end
    checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL t4_pkt_count got %0d want 5", pkt_count); end
    checks++; if (tx_sum !== 32'd172) begin errors++; $display("FAIL t4_tx_sum got %0d want 172", tx_sum); end
  endtask

  // Scenario 5: reset in the middle of a packet, then a clean packet.
  task automatic test_reset_mid_packet();
    m_axis_tready = 1'b0;
    for (int i = 21; i <= 24; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    tick();
    tick();
    checks++; if (m_axis_tdata !== 32'd23) begin errors++; $display("FAIL t5_mid_data got %0d want 23", m_axis_tdata); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t5_rst_valid got %b want 0", m_axis_tvalid); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL t5_rst_full got %b want 0", wr_full); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL t5_rst_pkt_count got %0d want 0", pkt_count); end
    checks++; if (tx_sum !== 32'd0) begin errors++; $display("FAIL t5_rst_tx_sum got %0d want 0", tx_sum); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_rst_busy got %b want 0", busy); end
    for (int i = 31; i <= 34; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t5_valid beat %0d got %b want 1", b, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'(31 + b)) begin errors++; $display("FAIL t5_data beat %0d got %0d want %0d", b, m_axis_tdata, 31 + b); end
      checks++; if (m_axis_tlast !== (b == 3)) begin errors++; $display("FAIL t5_last beat %0d got %b want %b", b, m_axis_tlast, (b == 3)); end
      tick();
    end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL t5_pkt_count got %0d want 1", pkt_count); end
    checks++; if (tx_sum !== 32'd130) begin errors++; $display("FAIL t5_tx_sum got %0d want 130", tx_sum); end
  endtask

  // Scenario 6: write and pop together at occupancy 5 keeps occupancy at 5.
  task automatic test_simultaneous();
    m_axis_tready = 1'b0;
    for (int i = 41; i <= 45; i++) begin
      wr_en = 1'b1; wr_data = 32'(i);
      tick();
    end
    checks++; if (m_axis_tdata !== 32'd41 || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t6_head got valid %b data %0d want valid 1 data 41", m_axis_tvalid, m_axis_tdata); end
    m_axis_tready = 1'b1;
    wr_data = 32'd46;
    tick();
    m_axis_tready = 1'b0;
    // Occupancy 5 -> three more writes reach full only if it stayed at 5.
    for (int i = 47; i <= 49; i++) begin
      wr_data = 32'(i);
      tick();
      if (i == 48) begin
        checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL t6_full_at7 got %b want 0", wr_full); end
      end
    end
    wr_en = 1'b0;
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL t6_full got %b want 1", wr_full); end
    m_axis_tready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL t6_valid beat %0d got %b want 1", b, m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'(42 + b)) begin errors++; $display("FAIL t6_data beat %0d got %0d want %0d", b, m_axis_tdata, 42 + b); end
      checks++; if (m_axis_tlast !== (b == 2 || b == 6)) begin errors++; $display("FAIL t6_last beat %0d got %b want %b", b, m_axis_tlast, (b == 2 || b == 6)); end
      tick();
    end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL t6_valid_end got %b want 0", m_axis_tvalid); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL t6_pkt_count got %0d want 3", pkt_count); end
    checks++; if (tx_sum !== 32'd486) begin errors++; $display("FAIL t6_tx_sum got %0d want 486", tx_sum); end
  endtask

  initial begin
    rst           = 1'b1;
    wr_en         = 1'b0;
    wr_data       = 32'd0;
    m_axis_tready = 1'b0;
    test_reset();
    test_basic_packet();
    test_partial_hold();
    test_backpressure();
    test_full_back_to_back();
    test_reset_mid_packet();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
